// File: rtl/mem_pkg.sv
// Shared SRAM driver types: control encodings, FSM states and the request record.
package mem_pkg;

   localparam int SRAM_AW = 18;

   typedef enum logic [1:0] {
      CTRL_IDLE  = 2'b00,
      CTRL_WRITE = 2'b01,
      CTRL_READ  = 2'b10,
      CTRL_RSVD  = 2'b11
   } ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RELEASE
   } state_e;

   // Address and word are already offset by the increment when captured.
   typedef struct packed {
      logic        is_write;
      logic [15:0] addr;
      logic [15:0] word;
   } req_t;

   function automatic logic is_access(input logic [1:0] ctrl);
      return (ctrl == CTRL_WRITE) || (ctrl == CTRL_READ);
   endfunction

endpackage

// File: rtl/sram_req_capture.sv
// Request detection for sram_driver: key compare against the last accepted
// request, a one-entry pending slot, and the sticky overrun flag.
module sram_req_capture
   import mem_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_control,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_data,
   input  logic [15:0] i_increment,
   input  logic        i_busy,
   output logic        o_take_valid,
   output req_t        o_take,
   output logic        o_overrun
);

   logic [17:0] r_last_key;
   logic        r_pend_valid;
   req_t        r_pend;
   logic        r_overrun;

   logic [17:0] w_key;
   logic        w_new;
   req_t        w_req;

   assign w_key = {i_control, i_increment};
   assign w_new = is_access(i_control) && (w_key != r_last_key);

   always_comb begin
      w_req          = '0;
      w_req.is_write = (i_control == CTRL_WRITE);
      w_req.addr     = i_addr + i_increment;
      w_req.word     = i_data + i_increment;
   end

   // A waiting pending entry always beats a fresh request.
   assign o_take_valid = !i_busy && (r_pend_valid || w_new);
   assign o_take       = r_pend_valid ? r_pend : w_req;
   assign o_overrun    = r_overrun;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_key   <= '0;
         r_pend_valid <= 1'b0;
         r_pend       <= '0;
         r_overrun    <= 1'b0;
      end else begin
         if (!is_access(i_control))
            r_last_key <= '0;
         else if (w_new)
            r_last_key <= w_key;

         if (!i_busy && r_pend_valid) begin
            r_pend_valid <= w_new;
            r_pend       <= w_req;
         end else if (i_busy && w_new) begin
            if (r_pend_valid)
               r_overrun <= 1'b1;
            r_pend_valid <= 1'b1;
            r_pend       <= w_req;
         end
      end
   end

endmodule

// File: rtl/sram_driver.sv
// Asynchronous SRAM access sequencer: SETUP / STROBE / RELEASE cycle per request.
// Optional read-back check enabled by defining SRAM_DRIVER_VERIFY_EN.
module sram_driver
   import mem_pkg::*;
#(
   parameter int         WAIT_CYCLES = 2,
   parameter logic [1:0] ADDR_HI     = 2'b00
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [15:0]        i_addr,
   input  logic [15:0]        i_data,
   input  logic [15:0]        i_increment,
   input  logic [1:0]         i_control,
   output logic [SRAM_AW-1:0] o_ram_addr,
   inout  wire  [15:0]        io_ram_data,
   output logic               o_ram_en_n,
   output logic               o_ram_oe_n,
   output logic               o_ram_we_n,
   output logic [15:0]        o_rdata,
   output logic               o_done,
   output logic               o_overrun,
   output logic               o_mismatch
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_e             r_state;
   logic               r_start;
   req_t               r_cur;
   logic [3:0]         r_cnt;
   logic [SRAM_AW-1:0] r_ram_addr;
   logic               r_en_n;
   logic               r_oe_n;
   logic               r_we_n;
   logic               r_drive;
   logic [15:0]        r_rdata;
   logic               r_done;

   logic               w_busy;
   logic               w_take_valid;
   req_t               w_take;

   // r_start marks an accepted request waiting one cycle before SETUP.
   assign w_busy = (r_state != ST_IDLE) || r_start;

   sram_req_capture u_capture (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_control    (i_control),
      .i_addr       (i_addr),
      .i_data       (i_data),
      .i_increment  (i_increment),
      .i_busy       (w_busy),
      .o_take_valid (w_take_valid),
      .o_take       (w_take),
      .o_overrun    (o_overrun)
   );

`ifdef SRAM_DRIVER_VERIFY_EN
   logic r_mismatch;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_mismatch <= 1'b0;
      else if (r_state == ST_STROBE && r_cnt == 4'd0 && !r_cur.is_write &&
               io_ram_data != r_cur.word)
         r_mismatch <= 1'b1;
   end

   assign o_mismatch = r_mismatch;
`else
   assign o_mismatch = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_start    <= 1'b0;
         r_cur      <= '0;
         r_cnt      <= '0;
         r_ram_addr <= '0;
         r_en_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_drive    <= 1'b0;
         r_rdata    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_start) begin
                  r_start    <= 1'b0;
                  r_state    <= ST_SETUP;
                  r_ram_addr <= {ADDR_HI, r_cur.addr};
                  r_en_n     <= 1'b0;
                  r_drive    <= r_cur.is_write;
               end else if (w_take_valid) begin
                  r_start <= 1'b1;
                  r_cur   <= w_take;
               end
            end
            ST_SETUP: begin
               r_state <= ST_STROBE;
               r_cnt   <= CNT_LOAD;
               if (r_cur.is_write)
                  r_we_n <= 1'b0;
               else
                  r_oe_n <= 1'b0;
            end
            ST_STROBE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RELEASE;
                  r_we_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_done  <= 1'b1;
                  if (!r_cur.is_write)
                     r_rdata <= io_ram_data;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_IDLE;
               r_en_n  <= 1'b1;
               r_drive <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_ram_data = r_drive ? r_cur.word : 16'hzzzz;
   assign o_ram_addr  = r_ram_addr;
   assign o_ram_en_n  = r_en_n;
   assign o_ram_oe_n  = r_oe_n;
   assign o_ram_we_n  = r_we_n;
   assign o_rdata     = r_rdata;
   assign o_done      = r_done;

endmodule

// File: tb/tb_sram_driver.sv
// Directed bench for sram_driver with a small behavioural SRAM on the data bus.
module tb_sram_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr, data, inc;
   logic [1:0]  control;
   logic [17:0] ram_addr;
   wire  [15:0] ram_data;
   logic        en_n, oe_n, we_n, done, overrun, mismatch;
   logic [15:0] rdata;

`ifdef SRAM_DRIVER_VERIFY_EN
   localparam logic EXP_MIS = 1'b1;
`else
   localparam logic EXP_MIS = 1'b0;
`endif

   logic [15:0] mem [0:255] = '{default: 16'h0000};
   logic        bad_read = 1'b0;

   sram_driver #(.WAIT_CYCLES(2), .ADDR_HI(2'b00)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_addr      (addr),
      .i_data      (data),
      .i_increment (inc),
      .i_control   (control),
      .o_ram_addr  (ram_addr),
      .io_ram_data (ram_data),
      .o_ram_en_n  (en_n),
      .o_ram_oe_n  (oe_n),
      .o_ram_we_n  (we_n),
      .o_rdata     (rdata),
      .o_done      (done),
      .o_overrun   (overrun),
      .o_mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   // SRAM model: drives the bus while enabled and output-enabled, stores on write strobe.
   assign ram_data = (!en_n && !oe_n) ? (bad_read ? 16'h1234 : mem[ram_addr[7:0]]) : 16'hzzzz;

   always @(posedge clk)
      if (!en_n && !we_n)
         mem[ram_addr[7:0]] <= ram_data;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int          n_we, n_oe, n_done, first_done;
   logic [17:0] cap_addr;
   logic [15:0] cap_wdata;

   // Observe n cycles at the falling edge; first_done is the index of the first done.
   task automatic watch(input int n);
      n_we = 0; n_oe = 0; n_done = 0; first_done = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (!we_n) begin
            n_we++;
            cap_addr  = ram_addr;
            cap_wdata = ram_data;
         end
         if (!oe_n) begin
            n_oe++;
            cap_addr = ram_addr;
         end
         if (done) begin
            n_done++;
            if (first_done == 0) first_done = i;
         end
      end
   endtask

   task automatic set_req(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] i);
      control = c; addr = a; data = d; inc = i;
   endtask

   task automatic txn(input string name);
      $display("txn %-8s ctrl=%b addr=%h data=%h inc=%h ram_addr=%h we=%0d oe=%0d dones=%0d done_at=%0d rdata=%h ovr=%b mis=%b",
               name, control, addr, data, inc, cap_addr, n_we, n_oe, n_done, first_done, rdata,
               overrun, mismatch);
   endtask

   task automatic idle_gap();
      control = 2'b00;
      watch(2);
   endtask

   logic found;

   initial begin
      rst_n = 1'b0;
      set_req(2'b00, 16'h0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      check("rst_en_n",   32'(en_n),     32'h1);
      check("rst_oe_n",   32'(oe_n),     32'h1);
      check("rst_we_n",   32'(we_n),     32'h1);
      check("rst_addr",   32'(ram_addr), 32'h0);
      check("rst_rdata",  32'(rdata),    32'h0);
      check("rst_done",   32'(done),     32'h0);
      check("rst_ovr",    32'(overrun),  32'h0);
      check("rst_mis",    32'(mismatch), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic write, held for many cycles: exactly one access.
      // Latency counts edges after the accepting edge (the first watched edge).
      set_req(2'b01, 16'h0100, 16'h00A0, 16'd3);
      watch(14);
      txn("write1");
      check("w1_addr",  32'(cap_addr),       32'h00103);
      check("w1_data",  32'(cap_wdata),      32'h00A3);
      check("w1_we",    32'(n_we),           32'd2);
      check("w1_oe",    32'(n_oe),           32'd0);
      check("w1_lat",   32'(first_done - 1), 32'd4);
      check("w1_once",  32'(n_done),         32'd1);
      check("w1_mem",   32'(mem[8'h03]),     32'h00A3);
      idle_gap();

      // Read back the same word.
      set_req(2'b10, 16'h0100, 16'h00A0, 16'd3);
      watch(12);
      txn("read1");
      check("r1_oe",    32'(n_oe),           32'd2);
      check("r1_we",    32'(n_we),           32'd0);
      check("r1_addr",  32'(cap_addr),       32'h00103);
      check("r1_rdata", 32'(rdata),          32'h00A3);
      check("r1_lat",   32'(first_done - 1), 32'd4);
      check("r1_mis",   32'(mismatch),       32'h0);
      idle_gap();

      // Address and data wrap silently.
      set_req(2'b01, 16'hFFFF, 16'hFFFE, 16'd2);
      watch(12);
      txn("wrap");
      check("wr_addr",  32'(cap_addr),  32'h00001);
      check("wr_data",  32'(cap_wdata), 32'h0000);
      check("wr_once",  32'(n_done),    32'd1);
      idle_gap();

      // inc 0,1,2 on consecutive cycles: inc=1 lands in pending, inc=2 overwrites it.
      set_req(2'b01, 16'h0200, 16'h0010, 16'd0);
      @(negedge clk);
      inc = 16'd1;
      @(negedge clk);
      inc = 16'd2;
      watch(30);
      txn("overrun");
      check("ov_dones", 32'(n_done),      32'd2);
      check("ov_flag",  32'(overrun),     32'h1);
      check("ov_addr",  32'(cap_addr),    32'h00202);
      check("ov_mem0",  32'(mem[8'h00]),  32'h0010);
      check("ov_mem1",  32'(mem[8'h01]),  32'h0000);
      check("ov_mem2",  32'(mem[8'h02]),  32'h0012);
      idle_gap();

      // control drops to idle one cycle after the request: access still completes.
      set_req(2'b01, 16'h0300, 16'h0050, 16'd5);
      @(negedge clk);
      control = 2'b00;
      watch(12);
      txn("drop");
      check("dr_once",  32'(n_done),     32'd1);
      check("dr_we",    32'(n_we),       32'd2);
      check("dr_mem",   32'(mem[8'h05]), 32'h0055);
      // Same key again after idle is a fresh request.
      control = 2'b01;
      watch(12);
      txn("reissue");
      check("ri_once",  32'(n_done),     32'd1);
      idle_gap();

      // Reset during the write strobe.
      set_req(2'b01, 16'h0400, 16'h0700, 16'd7);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (!we_n) found = 1'b1;
      end
      check("rs_strobe", 32'(found), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("rs_we_n",   32'(we_n),        32'h1);
      check("rs_en_n",   32'(en_n),        32'h1);
      check("rs_nowr",   32'(mem[8'h07]),  32'h0000);
      @(negedge clk);
      check("rs_ovr",    32'(overrun),     32'h0);
      rst_n = 1'b1;
      watch(12);
      txn("rstwrite");
      check("rs_once",   32'(n_done),           32'd1);
      check("rs_lat",    32'(first_done - 1),   32'd4);
      check("rs_data",   32'(cap_wdata),        32'h0707);
      check("rs_mem",    32'(mem[8'h07]),       32'h0707);
      idle_gap();

      // Corrupted read data raises the sticky read-back flag when the check is built in.
      bad_read = 1'b1;
      set_req(2'b10, 16'h0100, 16'h00A0, 16'd3);
      watch(12);
      bad_read = 1'b0;
      txn("badread");
      check("bd_rdata",  32'(rdata),    32'h1234);
      check("bd_mis",    32'(mismatch), 32'(EXP_MIS));
      idle_gap();
      control = 2'b10;
      watch(12);
      txn("goodread");
      check("gd_rdata",  32'(rdata),    32'h00A3);
      check("gd_sticky", 32'(mismatch), 32'(EXP_MIS));
      control = 2'b00;
      rst_n = 1'b0;
      @(negedge clk);
      check("gd_clear",  32'(mismatch), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
